// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage: register geometry, bubble encoding,
// and the bit positions of the MEM/WB write-back control field.
package wb_regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [31:0] NOP_BUBBLE = 32'h0;

  // MEM/WB write-back control field: {RegWrite, MemtoReg}
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  function automatic logic is_bubble(input logic [31:0] instr);
    return instr == NOP_BUBBLE;
  endfunction

endpackage

// File: rtl/wb_regfile_mux.sv
// 2:1 write-back select between load data and ALU result.
module wb_mux #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] mem_data,
  input  logic [W-1:0] alu_data,
  output logic [W-1:0] wb_data
);

  assign wb_data = sel ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, commits it to the register file,
// serves two bypassed read ports and tracks retired instructions.
module wb_regfile #(
  parameter int XLEN  = wb_regfile_pkg::XLEN,
  parameter int NREG  = wb_regfile_pkg::NREG,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [XLEN-1:0]  Memory_i,
  input  logic [XLEN-1:0]  ALU_i,
  input  logic [4:0]       RDaddr_i,
  input  logic [31:0]      Instruction_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  WBdata_o,
  output logic [CNT_W-1:0] Retired_o,
  output logic [4:0]       LastRD_o,
  output logic [XLEN-1:0]  LastData_o
);

  import wb_regfile_pkg::*;

  logic [1:0]       wb_ctrl;
  logic [XLEN-1:0]  wb_data;
  logic             wr_en;
  logic [XLEN-1:0]  regs [NREG];
  logic [CNT_W-1:0] retired_q;
  logic [4:0]       last_rd_q;
  logic [XLEN-1:0]  last_data_q;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;

  assign wb_ctrl[CTRL_REGWRITE] = RegWrite_i;
  assign wb_ctrl[CTRL_MEMTOREG] = MemtoReg_i;

  wb_mux #(.W(XLEN)) u_wb_mux (
    .sel      (wb_ctrl[CTRL_MEMTOREG]),
    .mem_data (Memory_i),
    .alu_data (ALU_i),
    .wb_data  (wb_data)
  );

  // Writes to x0 are dropped entirely, including the last-commit record.
  assign wr_en = wb_ctrl[CTRL_REGWRITE] && (RDaddr_i != REG_ZERO);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      retired_q   <= '0;
      last_rd_q   <= '0;
      last_data_q <= '0;
    end else begin
      if (wr_en) begin
        regs[RDaddr_i] <= wb_data;
        last_rd_q      <= RDaddr_i;
        last_data_q    <= wb_data;
      end
      if (!is_bubble(Instruction_i))
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Same-cycle bypass lets ID see a WB result without an extra stall.
  always_comb begin
    rs1_data = regs[RS1addr_i];
    if (RS1addr_i == REG_ZERO)
      rs1_data = '0;
    else if (wb_ctrl[CTRL_REGWRITE] && (RS1addr_i == RDaddr_i))
      rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[RS2addr_i];
    if (RS2addr_i == REG_ZERO)
      rs2_data = '0;
    else if (wb_ctrl[CTRL_REGWRITE] && (RS2addr_i == RDaddr_i))
      rs2_data = wb_data;
  end

  assign RS1data_o  = rs1_data;
  assign RS2data_o  = rs2_data;
  assign WBdata_o   = wb_data;
  assign Retired_o  = retired_q;
  assign LastRD_o   = last_rd_q;
  assign LastData_o = last_data_q;

endmodule
